// File: rtl/led_flash.sv
// led_flash: stretches single-cycle trigger pulses into visible LED flashes, blinks while locked, else mirrors level.
// Optional build macro LED_FLASH_ACTIVE_LOW_EN inverts the a_led pad polarity (on=0, reset value 1).
module led_flash #(
    parameter int unsigned FLASH_CMAX = 5_000_000,
    parameter int unsigned GAP_CMAX   = 5_000_000,
    parameter int unsigned BLINK_CMAX = 12_500_000,
    parameter int unsigned MAXQ       = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tr,
    input  logic lock,
    input  logic level,
    output logic a_led,
    output logic busy
);

    localparam int unsigned FG_MAX  = (FLASH_CMAX > GAP_CMAX) ? FLASH_CMAX : GAP_CMAX;
    localparam int unsigned CNT_MAX = (FG_MAX > BLINK_CMAX) ? FG_MAX : BLINK_CMAX;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned PW      = $clog2(MAXQ + 1);

`ifdef LED_FLASH_ACTIVE_LOW_EN
    localparam logic LED_ON = 1'b0;
`else
    localparam logic LED_ON = 1'b1;
`endif
    localparam logic LED_OFF = ~LED_ON;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FLASH_ON  = 2'd1,
        FLASH_GAP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   pend_q, pend_d, pend_inc;
    logic [CW-1:0]   blink_cnt_q, blink_cnt_d;
    logic            blink_ph_q, blink_ph_d;
    logic            led_on_d;
    logic            busy_d;

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pend_q      <= '0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b1;
            a_led       <= LED_OFF;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            a_led       <= led_on_d ? LED_ON : LED_OFF;
            busy        <= busy_d;
        end
    end

    // Next-state, request queue, blink timing and output decode
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        blink_cnt_d = '0;
        blink_ph_d  = 1'b1;
        led_on_d    = 1'b0;
        busy_d      = 1'b0;

        // Saturating count of requests that arrive while a flash is active
        pend_inc = (tr && (pend_q != PW'(MAXQ))) ? pend_q + PW'(1) : pend_q;

        case (state_q)
            IDLE: begin
                if (tr) begin
                    state_d = FLASH_ON;
                    cnt_d   = '0;
                end
            end
            FLASH_ON: begin
                pend_d = pend_inc;
                if (cnt_q == CW'(FLASH_CMAX - 1)) begin
                    state_d = FLASH_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FLASH_GAP: begin
                if (cnt_q == CW'(GAP_CMAX - 1)) begin
                    cnt_d = '0;
                    if (tr) begin
                        state_d = FLASH_ON;
                    end else if (pend_q != '0) begin
                        state_d = FLASH_ON;
                        pend_d  = pend_q - PW'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d  = cnt_q + CW'(1);
                    pend_d = pend_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                pend_d  = '0;
            end
        endcase

        // Blink runs only while idle and locked; otherwise held at its start point
        if ((state_q == IDLE) && lock) begin
            if (blink_cnt_q == CW'(BLINK_CMAX - 1)) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + CW'(1);
                blink_ph_d  = blink_ph_q;
            end
        end

        case (state_d)
            FLASH_ON: begin
                led_on_d = 1'b1;
                busy_d   = 1'b1;
            end
            FLASH_GAP: begin
                led_on_d = 1'b0;
                busy_d   = 1'b1;
            end
            default: begin
                led_on_d = lock ? blink_ph_q : level;
                busy_d   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_led_flash.sv
// Self-checking bench for led_flash: directed timing scenarios plus randomized traffic
// compared against a flash-period position model.
module tb_led_flash;

    localparam int F = 4;
    localparam int G = 3;
    localparam int B = 5;
    localparam int Q = 2;

`ifdef LED_FLASH_ACTIVE_LOW_EN
    localparam logic ACT_LOW = 1'b1;
`else
    localparam logic ACT_LOW = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic tr;
    logic lock;
    logic level;
    logic a_led;
    logic busy;

    int n_vec;
    int n_err;

    // Reference model: position inside the current on+gap period, queued count,
    // and number of consecutive idle-locked cycles.
    int   m_active;
    int   m_pos;
    int   m_pend;
    int   m_lk;
    logic exp_on;
    logic exp_busy;

    led_flash #(
        .FLASH_CMAX(F),
        .GAP_CMAX  (G),
        .BLINK_CMAX(B),
        .MAXQ      (Q)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .tr   (tr),
        .lock (lock),
        .level(level),
        .a_led(a_led),
        .busy (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void model_step(input logic t, input logic l, input logic v, input logic rn);
        logic phase;
        if (!rn) begin
            m_active = 0;
            m_pos    = 0;
            m_pend   = 0;
            m_lk     = 0;
            exp_on   = 1'b0;
            exp_busy = 1'b0;
            return;
        end
        phase = (((m_lk / B) % 2) == 0);
        m_lk  = ((m_active == 0) && l) ? m_lk + 1 : 0;
        if (m_active == 0) begin
            if (t) begin
                m_active = 1;
                m_pos    = 0;
            end
        end else if (m_pos == F + G - 1) begin
            if (t) m_pos = 0;
            else if (m_pend > 0) begin
                m_pend = m_pend - 1;
                m_pos  = 0;
            end else m_active = 0;
        end else begin
            m_pos = m_pos + 1;
            if (t && (m_pend < Q)) m_pend = m_pend + 1;
        end
        exp_on   = (m_active != 0) ? (m_pos < F) : (l ? phase : v);
        exp_busy = (m_active != 0);
    endfunction

    // Apply one cycle of inputs, advance the model, sample outputs 1 time unit after the edge.
    task automatic tick(input logic t, input logic l, input logic v, input logic rn);
        tr    = t;
        lock  = l;
        level = v;
        rst_n = rn;
        @(posedge clk);
        model_step(t, l, v, rn);
        #1;
        tr = 1'b0;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        n_vec++;
        if (a_led !== ACT_LOW) begin
            n_err++;
            $display("FAIL reset_a_led a_led=%b want %b", a_led, ACT_LOW);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_busy busy=%b want 0", busy);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_single_flash();
        logic eo, eb;
        settle(3);
        for (int j = 0; j < 12; j++) begin
            tick(j == 0, 1'b0, 1'b0, 1'b1);
            eo = ((j + 1) >= 1) && ((j + 1) <= F);
            eb = ((j + 1) <= F + G);
            n_vec++;
            if (a_led !== (eo ^ ACT_LOW)) begin
                n_err++;
                $display("FAIL single_a_led c=%0d a_led=%b want %b", j + 1, a_led, eo ^ ACT_LOW);
            end
            n_vec++;
            if (busy !== eb) begin
                n_err++;
                $display("FAIL single_busy c=%0d busy=%b want %b", j + 1, busy, eb);
            end
        end
    endtask

    task automatic test_queue_saturation();
        logic t, eo, eb;
        int c;
        settle(3);
        for (int j = 0; j < 26; j++) begin
            t = (j == 0) || (j >= 1 && j <= 3) || (j == 5) || (j == 6);
            tick(t, 1'b0, 1'b0, 1'b1);
            c  = j + 1;
            eb = (c <= 3 * (F + G));
            eo = eb && (((c - 1) % (F + G)) < F);
            n_vec++;
            if (a_led !== (eo ^ ACT_LOW)) begin
                n_err++;
                $display("FAIL queue_a_led c=%0d a_led=%b want %b", c, a_led, eo ^ ACT_LOW);
            end
            n_vec++;
            if (busy !== eb) begin
                n_err++;
                $display("FAIL queue_busy c=%0d busy=%b want %b", c, busy, eb);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic eo, eb;
        int c;
        settle(3);
        for (int j = 0; j < 18; j++) begin
            tick((j == 0) || (j == F + G), 1'b0, 1'b0, 1'b1);
            c  = j + 1;
            eb = (c <= 2 * (F + G));
            eo = (c >= 1 && c <= F) || (c >= F + G + 1 && c <= 2 * F + G);
            n_vec++;
            if (a_led !== (eo ^ ACT_LOW)) begin
                n_err++;
                $display("FAIL b2b_a_led c=%0d a_led=%b want %b", c, a_led, eo ^ ACT_LOW);
            end
            n_vec++;
            if (busy !== eb) begin
                n_err++;
                $display("FAIL b2b_busy c=%0d busy=%b want %b", c, busy, eb);
            end
        end
    endtask

    task automatic test_lock_blink();
        logic eo;
        int c;
        settle(3);
        for (int j = 0; j < 18; j++) begin
            tick(1'b0, (j <= 12), 1'b0, 1'b1);
            c  = j + 1;
            eo = (c <= 5) || (c >= 11 && c <= 13);
            n_vec++;
            if (a_led !== (eo ^ ACT_LOW)) begin
                n_err++;
                $display("FAIL blink_a_led c=%0d a_led=%b want %b", c, a_led, eo ^ ACT_LOW);
            end
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL blink_busy busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid_flash();
        settle(3);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (a_led !== (1'b1 ^ ACT_LOW)) begin
            n_err++;
            $display("FAIL midrst_pre a_led=%b want %b", a_led, 1'b1 ^ ACT_LOW);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (a_led !== ACT_LOW || busy !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_abort a_led=%b busy=%b want %b 0", a_led, busy, ACT_LOW);
        end
        for (int j = 0; j < 20; j++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b1);
            n_vec++;
            if (a_led !== ACT_LOW || busy !== 1'b0) begin
                n_err++;
                $display("FAIL midrst_after c=%0d a_led=%b busy=%b want %b 0", j, a_led, busy, ACT_LOW);
            end
        end
    endtask

    task automatic test_random();
        logic t, l, v, rn;
        l = 1'b0;
        for (int j = 0; j < 800; j++) begin
            t  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 19) == 0) l = ~l;
            v  = 1'($urandom_range(0, 1));
            rn = ($urandom_range(0, 149) != 0);
            tick(t, l, v, rn);
            n_vec++;
            if (a_led !== (exp_on ^ ACT_LOW)) begin
                n_err++;
                $display("FAIL rand_a_led j=%0d a_led=%b want %b", j, a_led, exp_on ^ ACT_LOW);
            end
            n_vec++;
            if (busy !== exp_busy) begin
                n_err++;
                $display("FAIL rand_busy j=%0d busy=%b want %b", j, busy, exp_busy);
            end
        end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        m_active = 0;
        m_pos    = 0;
        m_pend   = 0;
        m_lk     = 0;
        exp_on   = 1'b0;
        exp_busy = 1'b0;
        rst_n    = 1'b0;
        tr       = 1'b0;
        lock     = 1'b0;
        level    = 1'b0;

        test_reset();
        test_single_flash();
        test_queue_saturation();
        test_back_to_back();
        test_lock_blink();
        test_reset_mid_flash();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
